// File: rtl/lcd_write_arbiter.sv
// Two-port round-robin arbiter driving a HD44780-style LCD write cycle:
// latch RS/data, wait a setup time, pulse enable, hold low, then ack the winner.
module lcd_write_arbiter #(
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned EN_HIGH_CYCLES = 750000,
    parameter int unsigned EN_LOW_CYCLES  = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_on,
    output logic [7:0] lcd_data
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        EN_HIGH,
        EN_LOW
    } state_t;

    localparam logic [23:0] SETUP_LOAD   = 24'(SETUP_CYCLES - 1);
    localparam logic [23:0] EN_HIGH_LOAD = 24'(EN_HIGH_CYCLES - 1);
    localparam logic [23:0] EN_LOW_LOAD  = 24'(EN_LOW_CYCLES - 1);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        lcd_en_q, lcd_en_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic [7:0]  lcd_data_q, lcd_data_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        busy_q, busy_d;
    logic        winner;
    logic        cnt_zero;

    assign cnt_zero = (cnt_q == 24'd0);

    // On contention the port that did not win last time is served.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_grant_q;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        lcd_en_d     = lcd_en_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_data_d   = lcd_data_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    last_grant_d = winner;
                    lcd_rs_d     = winner ? rs1 : rs0;
                    lcd_data_d   = winner ? data1 : data0;
                    cnt_d        = SETUP_LOAD;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    cnt_d    = EN_HIGH_LOAD;
                    lcd_en_d = 1'b1;
                    state_d  = EN_HIGH;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            EN_HIGH: begin
                if (cnt_zero) begin
                    cnt_d    = EN_LOW_LOAD;
                    lcd_en_d = 1'b0;
                    state_d  = EN_LOW;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            EN_LOW: begin
                if (cnt_zero) begin
                    ack0_d  = ~last_grant_q;
                    ack1_d  = last_grant_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                lcd_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 24'd0;
            last_grant_q <= 1'b1;
            lcd_en_q     <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            lcd_en_q     <= lcd_en_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_data_q   <= lcd_data_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign busy     = busy_q;
    assign lcd_en   = lcd_en_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_data = lcd_data_q;
    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with short timing (1/3/2 clocks).
module tb_lcd_write_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       rs0 = 1'b0;
    logic       rs1 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       ack0, ack1, busy;
    logic       lcd_en, lcd_rs, lcd_rw, lcd_on;
    logic [7:0] lcd_data;

    int checks = 0;
    int errors = 0;

    lcd_write_arbiter #(
        .SETUP_CYCLES  (1),
        .EN_HIGH_CYCLES(3),
        .EN_LOW_CYCLES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .rs0     (rs0),
        .rs1     (rs1),
        .data0   (data0),
        .data1   (data1),
        .ack0    (ack0),
        .ack1    (ack1),
        .busy    (busy),
        .lcd_en  (lcd_en),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_on  (lcd_on),
        .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({lcd_en, lcd_rs, lcd_rw, lcd_on, ack0, ack1, busy} !== 7'b0001000) begin
            errors++;
            $display("FAIL reset_ctrl got en/rs/rw/on/ack0/ack1/busy=%b want 0001000",
                     {lcd_en, lcd_rs, lcd_rw, lcd_on, ack0, ack1, busy});
        end
        checks++;
        if (lcd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h want 00", lcd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || lcd_on !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle got busy=%b on=%b want 0 1", busy, lcd_on);
        end
    endtask

    task automatic test_single_write();
        logic exp_en, exp_busy, exp_ack;
        req0 = 1'b1; rs0 = 1'b0; data0 = 8'h38;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_en   = (k >= 2 && k <= 4);
            exp_busy = (k >= 1 && k <= 6);
            exp_ack  = (k == 7);
            checks++;
            if (lcd_en !== exp_en || busy !== exp_busy || ack0 !== exp_ack || ack1 !== 1'b0) begin
                errors++;
                $display("FAIL single_ctrl k=%0d got en=%b busy=%b ack0=%b ack1=%b want %b %b %b 0",
                         k, lcd_en, busy, ack0, ack1, exp_en, exp_busy, exp_ack);
            end
            checks++;
            if (lcd_data !== 8'h38 || lcd_rs !== 1'b0 || lcd_rw !== 1'b0) begin
                errors++;
                $display("FAIL single_bus k=%0d got data=%h rs=%b rw=%b want 38 0 0",
                         k, lcd_data, lcd_rs, lcd_rw);
            end
            if (k == 7) req0 = 1'b0;
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_data;
        logic       exp_rs;
        @(negedge clk);
        rst = 1'b1;
        req0 = 1'b1; rs0 = 1'b0; data0 = 8'hA0;
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'hB1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            exp_data = (t % 2 == 0) ? 8'hA0 : 8'hB1;
            exp_rs   = (t % 2 == 1);
            for (int c = 0; c < 7; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    checks++;
                    if (lcd_data !== exp_data || lcd_rs !== exp_rs || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL contention_grant t=%0d got data=%h rs=%b busy=%b want %h %b 1",
                                 t, lcd_data, lcd_rs, busy, exp_data, exp_rs);
                    end
                end
                if (c == 6) begin
                    checks++;
                    if (ack0 !== (t % 2 == 0) || ack1 !== (t % 2 == 1)) begin
                        errors++;
                        $display("FAIL contention_ack t=%0d got ack0=%b ack1=%b want %b %b",
                                 t, ack0, ack1, (t % 2 == 0), (t % 2 == 1));
                    end
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL contention_done got busy=%b want 0", busy);
        end
    endtask

    task automatic test_data_stability();
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h52;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (lcd_data !== 8'h52 || lcd_rs !== 1'b1) begin
                errors++;
                $display("FAIL stability k=%0d got data=%h rs=%b want 52 1", k, lcd_data, lcd_rs);
            end
            if (k == 3) begin
                data1 = 8'hFF;
                rs1   = 1'b0;
            end
            if (k == 7) begin
                checks++;
                if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
                    errors++;
                    $display("FAIL stability_ack got ack0=%b ack1=%b want 0 1", ack0, ack1);
                end
                req1 = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_abandoned();
        int acks = 0;
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h5A;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req1 = 1'b0;
            if (ack1 === 1'b1) acks++;
            checks++;
            if (busy !== (k <= 6) || ack1 !== (k == 7) || ack0 !== 1'b0) begin
                errors++;
                $display("FAIL abandoned k=%0d got busy=%b ack0=%b ack1=%b want %b 0 %b",
                         k, busy, ack0, ack1, (k <= 6), (k == 7));
            end
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL abandoned_count got %0d acks want 1", acks);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int acks = 0;
        req0 = 1'b1; rs0 = 1'b0; data0 = 8'h0C;
        for (int k = 1; k <= 3; k++) @(negedge clk);
        checks++;
        if (lcd_en !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre got en=%b want 1", lcd_en);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (lcd_en !== 1'b0 || busy !== 1'b0 || lcd_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_async got en=%b busy=%b data=%h want 0 0 00", lcd_en, busy, lcd_data);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) acks++;
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (busy !== 1'b1 || lcd_data !== 8'h0C) begin
                    errors++;
                    $display("FAIL midreset_regrant got busy=%b data=%h want 1 0c", busy, lcd_data);
                end
            end
            if (k < 7 && (ack0 === 1'b1 || ack1 === 1'b1)) acks++;
        end
        checks++;
        if (acks != 0 || ack0 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ack got stray=%0d ack0=%b want 0 1", acks, ack0);
        end
        req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int ph;
        int run = 0;
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h06;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            ph = (k - 1) % 7;
            checks++;
            if (busy !== (ph != 6) || lcd_en !== (ph >= 1 && ph <= 3) || ack0 !== (ph == 6)) begin
                errors++;
                $display("FAIL b2b k=%0d got busy=%b en=%b ack0=%b want %b %b %b",
                         k, busy, lcd_en, ack0, (ph != 6), (ph >= 1 && ph <= 3), (ph == 6));
            end
            if (lcd_en === 1'b1) begin
                run++;
            end else if (run != 0) begin
                checks++;
                if (run != 3) begin
                    errors++;
                    $display("FAIL b2b_en_width got %0d want 3", run);
                end
                run = 0;
            end
            if (k == 28) req0 = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_data_stability();
        test_abandoned();
        test_reset_mid_pulse();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
